// File: rtl/ascon_cfg.sv
// ascon_cfg: shared Ascon mode codes, sequencer state encoding, permutation
// lengths and control-word bit positions used by the round sequencer.
package ascon_cfg;

    // Mode codes (3'd5..3'd7 are undefined)
    localparam logic [2:0] ASCON_128  = 3'd0;
    localparam logic [2:0] ASCON_128A = 3'd1;
    localparam logic [2:0] ASCON_80PQ = 3'd2;
    localparam logic [2:0] ASCON_HASH = 3'd3;
    localparam logic [2:0] ASCON_XOF  = 3'd4;

    // Permutation lengths p^b
    localparam logic [3:0] PB_FULL = 4'd12;
    localparam logic [3:0] PB_128A = 4'd8;
    localparam logic [3:0] PB_128  = 4'd6;

    // Number of squeeze blocks for a plain hash
    localparam logic [7:0] HASH_BLOCKS = 8'd4;

    // Bit positions inside control_o
    localparam int CTRL_START     = 0;
    localparam int CTRL_PDO       = 1;
    localparam int CTRL_INIT_KEY  = 2;
    localparam int CTRL_SEP       = 3;
    localparam int CTRL_ABS_TEXT  = 4;
    localparam int CTRL_ABS_AD    = 5;
    localparam int CTRL_FINAL_CT  = 6;
    localparam int CTRL_EOT_KEY   = 7;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INIT_PERM  = 4'd1,
        ST_INIT_KEY   = 4'd2,
        ST_AD         = 4'd3,
        ST_AD_PERM    = 4'd4,
        ST_SEP        = 4'd5,
        ST_TEXT       = 4'd6,
        ST_TEXT_PERM  = 4'd7,
        ST_FINAL_PERM = 4'd8,
        ST_TAG        = 4'd9,
        ST_MSG        = 4'd10,
        ST_MSG_PERM   = 4'd11,
        ST_SQUEEZE    = 4'd12,
        ST_SQZ_PERM   = 4'd13
    } seq_state_e;

    function automatic logic mode_is_valid(input logic [2:0] mode);
        logic ok;
        case (mode)
            ASCON_128, ASCON_128A, ASCON_80PQ,
            ASCON_HASH, ASCON_XOF:              ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic mode_is_aead(input logic [2:0] mode);
        logic aead;
        case (mode)
            ASCON_128, ASCON_128A, ASCON_80PQ: aead = 1'b1;
            default:                           aead = 1'b0;
        endcase
        return aead;
    endfunction

    // Length of the permutation that follows a data block
    function automatic logic [3:0] data_rounds(input logic [2:0] mode);
        logic [3:0] b;
        case (mode)
            ASCON_128, ASCON_80PQ: b = PB_128;
            ASCON_128A:            b = PB_128A;
            default:               b = PB_FULL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/perm_round_counter.sv
// perm_round_counter: tracks the round-constant index of a p^b permutation
// executed R rounds per cycle. The first cycle starts at 12-b, each cycle
// advances by R, and the index is clamped to 12-R so the final cycle always
// finishes at round 11.
module perm_round_counter (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [3:0] b_i,
    input  logic       advance_i,
    input  logic [3:0] rpc_i,
    output logic [3:0] round_cnt_o,
    output logic       last_o
);

    logic [3:0] rc_q;
    logic [3:0] rc_d;
    logic [4:0] sum_s;
    logic [3:0] ceil_s;

    // Next round index: load on entry, step by R while running, clamp at 12-R
    always_comb begin
        sum_s  = {1'b0, rc_q} + {1'b0, rpc_i};
        ceil_s = 4'd12 - rpc_i;
        last_o = (sum_s >= 5'd12);
        rc_d   = rc_q;
        if (load_i) begin
            rc_d = 4'd12 - b_i;
        end else if (advance_i && !last_o) begin
            if (sum_s > {1'b0, ceil_s}) begin
                rc_d = ceil_s;
            end else begin
                rc_d = sum_s[3:0];
            end
        end else begin
            rc_d = rc_q;
        end
    end

    // Round index register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rc_q <= 4'd0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign round_cnt_o = rc_q;

endmodule

// File: rtl/ascon_sequencer.sv
// ascon_sequencer: control FSM that walks the Ascon state datapath through
// AEAD (init, AD, separation, text, finalisation, tag) and HASH/XOF
// (init, message absorb, finalisation, squeeze) phases. Block handshakes are
// answered in the same cycle the block is presented.
module ascon_sequencer
    import ascon_cfg::*;
#(
    parameter int ROUNDS_PER_CYCLE0 = 3,
    parameter int ROUNDS_PER_CYCLE1 = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [2:0] run_mode_i,
    input  logic       start_i,
    input  logic       decrypt_i,
    input  logic       ad_empty_i,
    input  logic [7:0] xof_blocks_i,
    input  logic       blk_valid_i,
    input  logic       blk_last_i,
    output logic       blk_ready_o,
    output logic       ready_o,
    output logic [7:0] control_o,
    output logic [3:0] round_cnt_o,
    output logic       out_valid_o,
    output logic       done_o
);

    localparam logic [3:0] RPC0_C = ROUNDS_PER_CYCLE0[3:0];
    localparam logic [3:0] RPC1_C = ROUNDS_PER_CYCLE1[3:0];

    seq_state_e state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic       decrypt_q, decrypt_d;
    logic       ad_empty_q, ad_empty_d;
    logic       ad_last_q, ad_last_d;
    logic [7:0] sqz_left_q, sqz_left_d;

    logic       start_accept_s;
    logic       aead_s;
    logic [3:0] data_b_s;
    logic [3:0] rpc_s;
    logic [7:0] ctrl_s;
    logic       blk_ready_s;
    logic       out_valid_s;
    logic       done_s;
    logic       cnt_load_s;
    logic [3:0] cnt_b_s;
    logic [3:0] cnt_rc_s;
    logic       cnt_last_s;

    assign start_accept_s = start_i && rst_n_i && (state_q == ST_IDLE);
    assign aead_s         = mode_is_aead(mode_q);
    assign data_b_s       = data_rounds(mode_q);
    assign rpc_s          = (mode_q == ASCON_128A) ? RPC1_C : RPC0_C;

    perm_round_counter u_perm_round_counter (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (cnt_load_s),
        .b_i         (cnt_b_s),
        .advance_i   (ctrl_s[CTRL_PDO]),
        .rpc_i       (rpc_s),
        .round_cnt_o (cnt_rc_s),
        .last_o      (cnt_last_s)
    );

    // Next-state, control word and handshake decode for the current phase
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        decrypt_d   = decrypt_q;
        ad_empty_d  = ad_empty_q;
        ad_last_d   = ad_last_q;
        sqz_left_d  = sqz_left_q;
        ctrl_s      = 8'h00;
        blk_ready_s = 1'b0;
        out_valid_s = 1'b0;
        done_s      = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_b_s     = PB_FULL;

        case (state_q)
            ST_IDLE: begin
                if (start_accept_s) begin
                    ctrl_s[CTRL_START] = 1'b1;
                    mode_d     = run_mode_i;
                    decrypt_d  = decrypt_i;
                    ad_empty_d = ad_empty_i;
                    ad_last_d  = 1'b0;
                    if (run_mode_i == ASCON_HASH) begin
                        sqz_left_d = HASH_BLOCKS;
                    end else if (run_mode_i == ASCON_XOF) begin
                        sqz_left_d = (xof_blocks_i == 8'd0) ? 8'd1 : xof_blocks_i;
                    end else begin
                        sqz_left_d = 8'd1;
                    end
                    cnt_load_s = 1'b1;
                    cnt_b_s    = PB_FULL;
                    state_d    = ST_INIT_PERM;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_INIT_PERM: begin
                // An undefined latched mode abandons the run silently
                if (!mode_is_valid(mode_q)) begin
                    state_d = ST_IDLE;
                end else begin
                    ctrl_s[CTRL_PDO] = 1'b1;
                    if (cnt_last_s) begin
                        state_d = aead_s ? ST_INIT_KEY : ST_MSG;
                    end else begin
                        state_d = ST_INIT_PERM;
                    end
                end
            end

            ST_INIT_KEY: begin
                ctrl_s[CTRL_INIT_KEY] = 1'b1;
                state_d = ad_empty_q ? ST_SEP : ST_AD;
            end

            ST_AD: begin
                if (blk_valid_i) begin
                    blk_ready_s            = 1'b1;
                    ctrl_s[CTRL_ABS_AD]    = 1'b1;
                    ctrl_s[CTRL_FINAL_CT]  = 1'b1;
                    ad_last_d              = blk_last_i;
                    cnt_load_s             = 1'b1;
                    cnt_b_s                = data_b_s;
                    state_d                = ST_AD_PERM;
                end else begin
                    state_d = ST_AD;
                end
            end

            ST_AD_PERM: begin
                ctrl_s[CTRL_PDO] = 1'b1;
                if (cnt_last_s) begin
                    state_d = ad_last_q ? ST_SEP : ST_AD;
                end else begin
                    state_d = ST_AD_PERM;
                end
            end

            ST_SEP: begin
                ctrl_s[CTRL_SEP] = 1'b1;
                state_d = ST_TEXT;
            end

            ST_TEXT: begin
                if (blk_valid_i) begin
                    blk_ready_s           = 1'b1;
                    ctrl_s[CTRL_FINAL_CT] = ~decrypt_q;
                    cnt_load_s            = 1'b1;
                    if (blk_last_i) begin
                        ctrl_s[CTRL_EOT_KEY] = 1'b1;
                        cnt_b_s              = PB_FULL;
                        state_d              = ST_FINAL_PERM;
                    end else begin
                        ctrl_s[CTRL_ABS_TEXT] = 1'b1;
                        cnt_b_s               = data_b_s;
                        state_d               = ST_TEXT_PERM;
                    end
                end else begin
                    state_d = ST_TEXT;
                end
            end

            ST_TEXT_PERM: begin
                ctrl_s[CTRL_PDO] = 1'b1;
                state_d = cnt_last_s ? ST_TEXT : ST_TEXT_PERM;
            end

            ST_MSG: begin
                if (blk_valid_i) begin
                    blk_ready_s           = 1'b1;
                    ctrl_s[CTRL_ABS_TEXT] = 1'b1;
                    ctrl_s[CTRL_FINAL_CT] = 1'b1;
                    cnt_load_s            = 1'b1;
                    cnt_b_s               = PB_FULL;
                    state_d               = blk_last_i ? ST_FINAL_PERM : ST_MSG_PERM;
                end else begin
                    state_d = ST_MSG;
                end
            end

            ST_MSG_PERM: begin
                ctrl_s[CTRL_PDO] = 1'b1;
                state_d = cnt_last_s ? ST_MSG : ST_MSG_PERM;
            end

            ST_FINAL_PERM: begin
                ctrl_s[CTRL_PDO] = 1'b1;
                if (cnt_last_s) begin
                    state_d = aead_s ? ST_TAG : ST_SQUEEZE;
                end else begin
                    state_d = ST_FINAL_PERM;
                end
            end

            ST_TAG: begin
                out_valid_s = 1'b1;
                done_s      = 1'b1;
                state_d     = ST_IDLE;
            end

            ST_SQUEEZE: begin
                out_valid_s = 1'b1;
                if (sqz_left_q <= 8'd1) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sqz_left_d = sqz_left_q - 8'd1;
                    cnt_load_s = 1'b1;
                    cnt_b_s    = PB_FULL;
                    state_d    = ST_SQZ_PERM;
                end
            end

            ST_SQZ_PERM: begin
                ctrl_s[CTRL_PDO] = 1'b1;
                state_d = cnt_last_s ? ST_SQUEEZE : ST_SQZ_PERM;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase register and per-run configuration latched at start
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= ASCON_128;
            decrypt_q  <= 1'b0;
            ad_empty_q <= 1'b0;
            ad_last_q  <= 1'b0;
            sqz_left_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            decrypt_q  <= decrypt_d;
            ad_empty_q <= ad_empty_d;
            ad_last_q  <= ad_last_d;
            sqz_left_q <= sqz_left_d;
        end
    end

    assign ready_o     = (state_q == ST_IDLE);
    assign control_o   = ctrl_s;
    assign blk_ready_o = blk_ready_s;
    assign out_valid_o = out_valid_s;
    assign done_o      = done_s;
    assign round_cnt_o = ctrl_s[CTRL_PDO] ? cnt_rc_s : 4'd0;

endmodule

// File: tb/tb_ascon_sequencer.sv
// tb_ascon_sequencer: scoreboard bench. Each scenario builds per-cycle
// stimulus and the expected outputs side by side in queues; run_queue then
// drives each cycle and compares what the sequencer produces.
module tb_ascon_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [2:0] run_mode_i;
    logic       start_i;
    logic       decrypt_i;
    logic       ad_empty_i;
    logic [7:0] xof_blocks_i;
    logic       blk_valid_i;
    logic       blk_last_i;
    logic       blk_ready_o;
    logic       ready_o;
    logic [7:0] control_o;
    logic [3:0] round_cnt_o;
    logic       out_valid_o;
    logic       done_o;

    ascon_sequencer #(.ROUNDS_PER_CYCLE0(3), .ROUNDS_PER_CYCLE1(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .run_mode_i   (run_mode_i),
        .start_i      (start_i),
        .decrypt_i    (decrypt_i),
        .ad_empty_i   (ad_empty_i),
        .xof_blocks_i (xof_blocks_i),
        .blk_valid_i  (blk_valid_i),
        .blk_last_i   (blk_last_i),
        .blk_ready_o  (blk_ready_o),
        .ready_o      (ready_o),
        .control_o    (control_o),
        .round_cnt_o  (round_cnt_o),
        .out_valid_o  (out_valid_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       start;
        logic [2:0] mode;
        logic       dec;
        logic       ade;
        logic [7:0] xof;
        logic       bv;
        logic       bl;
    } stim_t;

    // flags = {out_valid, done, blk_ready, ready}
    typedef struct packed {
        logic [7:0] ctrl;
        logic [3:0] rc;
        logic [3:0] flags;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    int    n_cmp  = 0;
    int    n_fail = 0;
    string cur_test;

    logic [2:0] cfg_mode;
    logic       cfg_dec;
    logic       cfg_ade;
    logic [7:0] cfg_xof;

    task automatic push(input logic st, input logic bv, input logic bl,
                        input logic [7:0] ctrl, input logic [3:0] rc, input logic [3:0] flags);
        stim_t s;
        exp_t  e;
        s.start = st; s.mode = cfg_mode; s.dec = cfg_dec; s.ade = cfg_ade;
        s.xof = cfg_xof; s.bv = bv; s.bl = bl;
        e.ctrl = ctrl; e.rc = rc; e.flags = flags;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expected p^b: ceil(b/R) cycles, index min(12-b+k*R, 12-R)
    task automatic push_perm(input int b, input int r, input logic noise);
        int n;
        int rc;
        n = (b + r - 1) / r;
        for (int k = 0; k < n; k++) begin
            rc = 12 - b + k * r;
            if (rc > 12 - r) rc = 12 - r;
            push(noise, noise, 1'b0, 8'h02, rc[3:0], 4'b0000);
        end
    endtask

    task automatic push_start();
        push(1'b1, 1'b0, 1'b0, 8'h01, 4'd0, 4'b0001);
    endtask

    task automatic push_idle();
        push(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'b0001);
    endtask

    task automatic run_queue(input int limit);
        stim_t s;
        exp_t  e;
        int    n;
        n = 0;
        while ((exp_q.size() > 0) && (n < limit)) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            start_i = s.start; run_mode_i = s.mode; decrypt_i = s.dec;
            ad_empty_i = s.ade; xof_blocks_i = s.xof;
            blk_valid_i = s.bv; blk_last_i = s.bl;
            @(negedge clk_i);
            n_cmp++;
            if (control_o !== e.ctrl) begin
                n_fail++;
                $display("FAIL %s[%0d] control_o got %h expected %h", cur_test, n, control_o, e.ctrl);
            end
            n_cmp++;
            if (round_cnt_o !== e.rc) begin
                n_fail++;
                $display("FAIL %s[%0d] round_cnt_o got %0d expected %0d", cur_test, n, round_cnt_o, e.rc);
            end
            n_cmp++;
            if ({out_valid_o, done_o, blk_ready_o, ready_o} !== e.flags) begin
                n_fail++;
                $display("FAIL %s[%0d] {ov,done,brdy,rdy} got %b expected %b", cur_test, n,
                         {out_valid_o, done_o, blk_ready_o, ready_o}, e.flags);
            end
            @(posedge clk_i);
            #1;
            n++;
        end
    endtask

    task automatic check_idle_outputs(input string what);
        n_cmp++;
        if ({control_o, round_cnt_o, out_valid_o, done_o, blk_ready_o, ready_o} !== {8'h00, 4'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL %s outputs got ctrl=%h rc=%0d ov=%b done=%b brdy=%b rdy=%b expected all 0 with rdy=1",
                     what, control_o, round_cnt_o, out_valid_o, done_o, blk_ready_o, ready_o);
        end
    endtask

    // Full ASCON_128 encrypt: one AD block, one text block
    task automatic build_aead128();
        cfg_mode = 3'd0; cfg_dec = 1'b0; cfg_ade = 1'b0; cfg_xof = 8'd0;
        push_start();
        push_perm(12, 3, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h04, 4'd0, 4'b0000);
        push(1'b0, 1'b1, 1'b1, 8'h60, 4'd0, 4'b0010);
        push_perm(6, 3, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h08, 4'd0, 4'b0000);
        push(1'b0, 1'b1, 1'b1, 8'hC0, 4'd0, 4'b0010);
        push_perm(12, 3, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'b1100);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        start_i = 1'b0; run_mode_i = 3'd0; decrypt_i = 1'b0; ad_empty_i = 1'b0;
        xof_blocks_i = 8'd0; blk_valid_i = 1'b0; blk_last_i = 1'b0;
        rst_n_i = 1'b0;
        #12;
        check_idle_outputs("reset_active");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("reset_released");
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_aead128();
        cur_test = "aead128";
        build_aead128();
        push_idle();
        run_queue(1000);
    endtask

    task automatic test_aead128a_decrypt();
        cur_test = "aead128a_dec";
        cfg_mode = 3'd1; cfg_dec = 1'b1; cfg_ade = 1'b1; cfg_xof = 8'd0;
        push_start();
        push_perm(12, 2, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h04, 4'd0, 4'b0000);
        push(1'b0, 1'b0, 1'b0, 8'h08, 4'd0, 4'b0000);
        push(1'b0, 1'b1, 1'b0, 8'h10, 4'd0, 4'b0010);
        push_perm(8, 2, 1'b0);
        push(1'b0, 1'b1, 1'b1, 8'h80, 4'd0, 4'b0010);
        push_perm(12, 2, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'b1100);
        push_idle();
        run_queue(1000);
    endtask

    // ASCON_80PQ, two AD blocks with a 5-cycle stall, stray start/valid while permuting
    task automatic test_stall_ad();
        cur_test = "stall_ad";
        cfg_mode = 3'd2; cfg_dec = 1'b0; cfg_ade = 1'b0; cfg_xof = 8'd0;
        push_start();
        push_perm(12, 3, 1'b1);
        push(1'b0, 1'b0, 1'b0, 8'h04, 4'd0, 4'b0000);
        for (int i = 0; i < 5; i++) push(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 4'b0000);
        push(1'b0, 1'b1, 1'b0, 8'h60, 4'd0, 4'b0010);
        push_perm(6, 3, 1'b1);
        for (int i = 0; i < 5; i++) push(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'b0000);
        push(1'b0, 1'b1, 1'b1, 8'h60, 4'd0, 4'b0010);
        push_perm(6, 3, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h08, 4'd0, 4'b0000);
        push(1'b0, 1'b1, 1'b0, 8'h50, 4'd0, 4'b0010);
        push_perm(6, 3, 1'b0);
        push(1'b0, 1'b1, 1'b1, 8'hC0, 4'd0, 4'b0010);
        push_perm(12, 3, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'b1100);
        push_idle();
        run_queue(1000);
    endtask

    task automatic build_hash_like(input logic [2:0] mode, input logic [7:0] xof,
                                   input int msg_blocks, input int out_blocks);
        cfg_mode = mode; cfg_dec = 1'b1; cfg_ade = 1'b0; cfg_xof = xof;
        push_start();
        push_perm(12, 3, 1'b0);
        for (int m = 0; m < msg_blocks; m++) begin
            push(1'b0, 1'b1, (m == msg_blocks - 1), 8'h50, 4'd0, 4'b0010);
            push_perm(12, 3, 1'b0);
        end
        for (int j = 0; j < out_blocks; j++) begin
            if (j == out_blocks - 1) begin
                push(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'b1100);
            end else begin
                push(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'b1000);
                push_perm(12, 3, 1'b0);
            end
        end
        push_idle();
    endtask

    task automatic test_hash();
        cur_test = "hash";
        build_hash_like(3'd3, 8'd9, 1, 4);
        run_queue(1000);
    endtask

    task automatic test_xof();
        cur_test = "xof_zero";
        build_hash_like(3'd4, 8'd0, 1, 1);
        run_queue(1000);
        cur_test = "xof_three";
        build_hash_like(3'd4, 8'd3, 2, 3);
        run_queue(1000);
    endtask

    task automatic test_bad_mode();
        cur_test = "bad_mode";
        cfg_mode = 3'd7; cfg_dec = 1'b0; cfg_ade = 1'b0; cfg_xof = 8'd0;
        push_start();
        push(1'b0, 1'b1, 1'b1, 8'h00, 4'd0, 4'b0000);
        push_idle();
        push_idle();
        run_queue(1000);
    endtask

    // Reset in the middle of the final permutation, then a clean run
    task automatic test_reset_mid();
        cur_test = "reset_mid";
        build_aead128();
        run_queue(13);
        stim_q.delete();
        exp_q.delete();
        start_i = 1'b0; blk_valid_i = 1'b0; blk_last_i = 1'b0;
        n_cmp++;
        if (control_o !== 8'h02) begin
            n_fail++;
            $display("FAIL reset_mid pre-reset control_o got %h expected 02", control_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_idle_outputs("reset_mid_held");
        end
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_idle_outputs("reset_mid_after");
            @(posedge clk_i);
            #1;
        end
        cur_test = "back_to_back";
        build_aead128();
        push_idle();
        run_queue(1000);
    endtask

    initial begin
        test_reset();
        test_aead128();
        test_aead128a_decrypt();
        test_stall_ad();
        test_hash();
        test_xof();
        test_bad_mode();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_sequencer.md
ASCON_SEQUENCER -- requirements
Module: ascon_sequencer

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE0, default 3, rounds per cycle for non-128a modes.
REQ-002 SHALL have parameter ROUNDS_PER_CYCLE1, default 2, rounds per cycle for ASCON_128A.
REQ-003 SHALL have clk_i  input  1  clock, rising edge.
REQ-004 SHALL have rst_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have run_mode_i  input  3  mode code from the shared ascon_cfg package, sampled at start.
REQ-006 SHALL have start_i  input  1  request a new function, accepted when ready_o=1.
REQ-007 SHALL have decrypt_i  input  1  AEAD direction, sampled at start.
REQ-008 SHALL have ad_empty_i  input  1  no associated data, sampled at start.
REQ-009 SHALL have xof_blocks_i  input  8  XOF squeeze block count, sampled at start; 0 is treated as 1.
REQ-010 SHALL have blk_valid_i / blk_last_i  input  1 each  data block present / final block of the current phase.
REQ-011 SHALL have blk_ready_o  output  1  block consumed this cycle.
REQ-012 SHALL have ready_o  output  1  idle and able to accept start_i.
REQ-013 SHALL have control_o  output  8  {eot_add_key, final_ct, abs_ad_do, abs_text_do, sep_domain, init_add_key, pdo, start} to the state datapath.
REQ-014 SHALL have round_cnt_o  output  4  round-constant index of the first round executed this cycle.
REQ-015 SHALL have out_valid_o  output  1  state holds a tag or hash/XOF output block for one cycle.
REQ-016 SHALL have done_o  output  1  one-cycle pulse when the function completes.

Function
REQ-017 SHALL accept start only when start_i=1 and ready_o=1, driving control_o=8'h01 in that cycle and latching mode, decrypt and ad_empty.
REQ-018 SHALL compute rounds/cycle R as ROUNDS_PER_CYCLE1 for ASCON_128A and ROUNDS_PER_CYCLE0 otherwise.
REQ-019 SHALL run permutation p^b as ceil(b/R) consecutive cycles with pdo=1 and round_cnt_o = 12-b, then +R each cycle, clamped so the final cycle ends at round 11.
REQ-020 SHALL use b=12 for init and final; data b=6 for ASCON_128 and ASCON_80PQ, b=8 for ASCON_128A, b=12 for HASH/XOF.
REQ-021 SHALL sequence AEAD states: IDLE -> INIT_PERM -> INIT_KEY -> AD (skipped if ad_empty) -> SEP -> TEXT -> FINAL_PERM -> TAG -> IDLE.
REQ-022 SHALL sequence HASH/XOF states: IDLE -> INIT_PERM -> MSG -> FINAL_PERM -> SQUEEZE -> IDLE.
REQ-023 SHALL assert init_add_key for one cycle in INIT_KEY, and sep_domain for one cycle in SEP.
REQ-024 SHALL, for a non-last AD block, assert blk_ready_o together with abs_ad_do and final_ct=1, followed by a p^b.
REQ-025 SHALL, for a non-last text block, assert abs_text_do with final_ct=~decrypt (HASH message: final_ct=1), followed by p^b.
REQ-026 SHALL, for the last text/message block, assert eot_add_key (AEAD) or abs_text_do (HASH/XOF) with the same final_ct rule, followed by FINAL_PERM with no p^b.
REQ-027 SHALL, for the last AD block, absorb it, run p^b, then enter SEP.
REQ-028 SHALL hold all control bits at 0 while blk_valid_i=0 in an absorb state (stall), at most one absorb bit per cycle.
REQ-029 SHALL, in TAG, pulse out_valid_o and done_o together.
REQ-030 SHALL, in SQUEEZE, pulse out_valid_o per block (HASH 4 blocks, XOF xof_blocks_i blocks), insert p^12 between blocks, and pulse done_o with the last out_valid_o.
REQ-031 SHALL ignore start_i while busy and ignore blk_valid_i outside absorb states.
REQ-032 SHALL return to IDLE without done_o if run_mode_i latched an undefined code.

Reset
REQ-033 SHALL on rst_n_i=0 immediately force IDLE with ready_o=1 and all other outputs 0, including mid-operation; no done_o follows.

Structure
REQ-034 SHALL take mode codes from ascon_cfg; the state enum and the b constants (12/8/6) SHALL be added to ascon_cfg.
REQ-035 SHALL contain one sub-module, perm_round_counter (p^b cycle counter producing round_cnt_o and a last-cycle flag).

Verification
REQ-036 ASCON_128 encrypt with 1 AD and 1 text block (both last): control sequence 01, 02x4, 04, 20|40, 02x2, 08, C0, 02x4, then out_valid_o=done_o=1; total 16 cycles.
REQ-037 ASCON_128A with ad_empty=1, decrypt, 2 text blocks: no abs_ad_do; first block is 10 then 02x4 at round_cnt 4,6,8,10; last block is 80.
REQ-038 HASH with 1 message block: the squeeze phase shows 4 out_valid_o pulses with 4 cycles of 02 between each pair, and done_o is asserted on the fourth pulse.
REQ-039 XOF with xof_blocks_i=0: produces exactly 1 out_valid_o pulse.
REQ-040 Stall blk_valid_i=0 for 5 cycles in AD: control_o=0 and blk_ready_o=0 throughout; sequence then resumes unchanged.
REQ-041 Assert rst_n_i=0 during FINAL_PERM: outputs 0 asynchronously and ready_o=1; the next start succeeds.
